uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised UART transmitter: the next generation of the class serial transmit path. It accepts bytes from the processor's output port into an internal FIFO. It serialises them back to back onto `transfer` with a per-frame selectable format: 7/8 data bits, optional even/odd parity, 1/2 stop bits. It sits between the processor I/O decode (load strobe) and the board TX pin, with status flags for polled or interrupt-driven use.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `K_W`, default 20: width of the baud divisor `k`.
- `clk`  in  1: system clock, all logic on rising edge.
- `reset`  in  1: reset is synchronous and active-low.
- `load`  in  1: one-cycle write strobe; pushes `out_port` into the FIFO.
- `out_port`  in  8: byte to transmit; bit 7 ignored in 7-bit frames.
- `eight`  in  1: 1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1: parity enable.
- `ohel`  in  1: parity sense; 1 = odd, 0 = even.
- `stop2`  in  1: 1 = two stop bits, 0 = one.
- `k`  in  K_W: clocks per bit; 0 is treated as 1.
- `ovf_clr`  in  1: clears `overflow`.
- `txrdy`  out  1: FIFO not full; a `load` is accepted.
- `fifo_count`  out  $clog2(DEPTH)+1: entries held, 0..DEPTH.
- `tx_busy`  out  1: a frame is on the line.
- `tx_done`  out  1: one-cycle pulse at the end of each frame's last stop bit.
- `overflow`  out  1: sticky; a `load` was dropped because the FIFO was full.
- `transfer`  out  1: serial line, registered, idles high.

## Operation
- FIFO: circular buffer with read/write pointers wrapping modulo DEPTH. Full and empty are judged on the count registered before the current edge.
- `load` with `fifo_count < DEPTH`: byte written, count +1.
- `load` when full: byte dropped, `overflow` set. This holds even if a pop occurs in the same cycle.
- Simultaneous accepted push and pop: count unchanged.
- `ovf_clr` with a dropped `load` in the same cycle: `overflow` stays 1, because set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is not empty, pop the head byte into the shift register. In the same cycle, latch `eight`, `pen`, `ohel`, `stop2` and `k`, then go to START. These inputs are ignored mid-frame.
- START: drive `transfer` = 0 for one bit time, then go to DATA.
- DATA: drive the data bits LSB first, 7 or 8 bits. Then go to PARITY if `pen`, else STOP.
- PARITY: bit = XOR of the data bits sent, inverted when `ohel` = 1. This gives even or odd total ones over data plus parity.
- STOP: drive `transfer` = 1 for 1 or 2 bit times.
- At the end of STOP: pulse `tx_done`. If the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length in bits = 1 + (7 or 8) + `pen` + (1 or 2), so 9 to 12 bits.
- Bit timer: counts 0..k−1 and wraps, advancing the bit at wrap. Each bit is exactly k clocks. It restarts at 0 at frame start.
- `tx_busy` = 1 in every state except IDLE.

## Timing
- Reset values: `transfer` = 1, `txrdy` = 1, `fifo_count` = 0, `tx_busy` = 0, `tx_done` = 0, `overflow` = 0. FSM goes to IDLE and pointers to 0.
- Reset mid-frame: on the next edge the line goes high and the FIFO contents are discarded.
- Accepted `load` at edge n into an empty FIFO with the FSM in IDLE:
  - `fifo_count` = 1 after edge n.
  - Pop and config latch at edge n+1, where `fifo_count` returns to 0 and `tx_busy` rises.
  - `transfer` falls after edge n+1 and the start bit runs k clocks.
- `txrdy` = (`fifo_count` != DEPTH), combinational from the registered count. It updates the cycle after a push or pop.
- `tx_done` is high for the single cycle after the last stop bit's final clock. `tx_busy` falls in the same cycle if the FIFO is empty.
- Back to back: the next start bit's first clock immediately follows the last stop clock, with no high gap beyond the stop bits.
- `ovf_clr` clears `overflow` on the next edge.

## Test plan
- 8N1, k=4, load 0x55 → `transfer` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, 40 clocks total; one `tx_done` pulse; `tx_busy` low afterwards.
- 7E1, k=2, load 0xC1 → data 1,0,0,0,0,0,1 (bit 7 ignored), parity 0, one stop bit; 10 bits, 20 clocks.
- 8O2, k=3, load 0xA5 → data 1,0,1,0,0,1,0,1, parity 1, two stop bits; 12 bits, 36 clocks.
- DEPTH=8, k=1000, 10 consecutive loads 0x00..0x09:
  - the first is popped at once, so `fifo_count` peaks at 8;
  - `txrdy` = 0;
  - the 10th load is dropped and `overflow` = 1;
  - output order is 0x00..0x08;
  - `ovf_clr` clears `overflow`.
- Two loads, 0x3C then 0xF0, 8N1, k=5 → frames contiguous, the second start bit begins on the clock after the first stop bit; `tx_done` pulses twice, 50 clocks apart.
- Assert `reset` low mid-DATA with 3 bytes queued → next cycle: `transfer` = 1, `fifo_count` = 0, `tx_busy` = 0, `txrdy` = 1; no further frame is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a serialiser with per-frame
// selectable 7/8 data bits, optional even/odd parity and 1/2 stop bits.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned K_W   = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [7:0]                 out_port,
  input  logic                       eight,
  input  logic                       pen,
  input  logic                       ohel,
  input  logic                       stop2,
  input  logic [K_W-1:0]             k,
  input  logic                       ovf_clr,
  output logic                       txrdy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       tx_busy,
  output logic                       tx_done,
  output logic                       overflow,
  output logic                       transfer
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic [7:0]     shreg;
  logic           eight_q, pen_q, stop2_q, par_q;
  logic [K_W-1:0] k_q, tick;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic           push, pop, wrap, frame_end;

  // Full/empty come from the count registered before this edge.
  always_comb begin
    push      = load && (count != CW'(DEPTH));
    wrap      = (tick == k_q - K_W'(1));
    frame_end = (state == STOP) && wrap && (stop_idx == stop2_q);
    pop       = (count != '0) && ((state == IDLE) || frame_end);
  end

  assign fifo_count = count;
  assign txrdy      = (count != CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= out_port;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      transfer <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      eight_q  <= 1'b1;
      pen_q    <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      k_q      <= K_W'(1);
    end else begin
      tx_done <= 1'b0;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      // A dropped load beats a simultaneous clear.
      if (load && !push)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;

      if (pop) begin
        shreg    <= mem[rptr];
        eight_q  <= eight;
        pen_q    <= pen;
        stop2_q  <= stop2;
        par_q    <= (eight ? ^mem[rptr] : ^mem[rptr][6:0]) ^ ohel;
        k_q      <= (k == '0) ? K_W'(1) : k;
        tick     <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        state    <= START;
        transfer <= 1'b0;
        tx_busy  <= 1'b1;
        if (frame_end) tx_done <= 1'b1;
      end else begin
        tick <= wrap ? '0 : tick + K_W'(1);
        case (state)
          IDLE: begin
            tick     <= '0;
            transfer <= 1'b1;
            tx_busy  <= 1'b0;
          end
          START: if (wrap) begin
            state    <= DATA;
            transfer <= shreg[0];
          end
          DATA: if (wrap) begin
            if (bit_idx == (eight_q ? 3'd7 : 3'd6)) begin
              if (pen_q) begin
                state    <= PARITY;
                transfer <= par_q;
              end else begin
                state    <= STOP;
                transfer <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              shreg    <= {1'b0, shreg[7:1]};
              transfer <= shreg[1];
            end
          end
          PARITY: if (wrap) begin
            state    <= STOP;
            transfer <= 1'b1;
          end
          STOP: if (wrap) begin
            if (frame_end) begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              transfer <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-and-frame reference model checked every cycle,
// directed scenarios plus randomized traffic.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned K_W   = 20;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_i, ld, eight_i, pen_i, ohel_i, stop2_i, clr;
  logic [7:0]     din;
  logic [K_W-1:0] k_i;
  logic           txrdy, tx_busy, tx_done, overflow, transfer;
  logic [CW-1:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus the expected bit list of the frame on the line.
  logic [7:0] q[$];
  logic [11:0] fbits;
  int  fk, flen, pos;
  bit  in_frame, m_ovf, exp_done;
  int  cyc = 0, n_done = 0, done_last = 0, done_prev = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .K_W(K_W)) dut (
    .clk(clk), .reset(rst_i), .load(ld), .out_port(din), .eight(eight_i),
    .pen(pen_i), .ohel(ohel_i), .stop2(stop2_i), .k(k_i), .ovf_clr(clr),
    .txrdy(txrdy), .fifo_count(fifo_count), .tx_busy(tx_busy),
    .tx_done(tx_done), .overflow(overflow), .transfer(transfer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_frame();
    logic [7:0] b;
    int nb, ones;
    b = q.pop_front();
    fbits = '0;
    nb = 1;
    ones = 0;
    for (int i = 0; i < (eight_i ? 8 : 7); i++) begin
      fbits[nb] = b[i];
      ones += int'(b[i]);
      nb++;
    end
    if (pen_i) begin
      fbits[nb] = 1'((ones % 2) ^ int'(ohel_i));
      nb++;
    end
    fbits[nb] = 1'b1;
    nb++;
    if (stop2_i) begin
      fbits[nb] = 1'b1;
      nb++;
    end
    fk = (k_i == '0) ? 1 : int'(k_i);
    flen = nb * fk;
    pos = 0;
    in_frame = 1;
  endtask

  // Apply the inputs present at the last rising edge to the model.
  task automatic model_edge();
    bit accept, popnow;
    int cnt_before;
    exp_done = 0;
    if (!rst_i) begin
      q.delete();
      in_frame = 0;
      pos = 0;
      m_ovf = 0;
    end else begin
      cnt_before = q.size();
      if (in_frame) begin
        pos++;
        if (pos == flen) begin
          in_frame = 0;
          exp_done = 1;
        end
      end
      popnow = !in_frame && (cnt_before > 0);
      accept = ld && (cnt_before < int'(DEPTH));
      if (popnow) start_frame();
      if (accept) q.push_back(din);
      if (ld && !accept) m_ovf = 1;
      else if (clr)      m_ovf = 0;
    end
  endtask

  task automatic step();
    logic exp_tx;
    @(negedge clk);
    cyc++;
    model_edge();
    exp_tx = in_frame ? fbits[pos / fk] : 1'b1;
    check("transfer", 32'(transfer), 32'(exp_tx));
    check("tx_busy", 32'(tx_busy), 32'(in_frame));
    check("tx_done", 32'(tx_done), 32'(exp_done));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("txrdy", 32'(txrdy), 32'(q.size() != int'(DEPTH)));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (tx_done === 1'b1) begin
      n_done++;
      done_prev = done_last;
      done_last = cyc;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (tx_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic set_cfg(input logic e, input logic p, input logic o, input logic s2, input int kk);
    eight_i = e; pen_i = p; ohel_i = o; stop2_i = s2; k_i = K_W'(kk);
  endtask

  task automatic load_byte(input logic [7:0] b);
    ld = 1'b1;
    din = b;
    step();
    ld = 1'b0;
  endtask

  initial begin
    int n, d0;
    rst_i = 1'b0; ld = 1'b0; din = '0; clr = 1'b0;
    set_cfg(1, 0, 0, 0, 4);
    repeat (2) step();
    rst_i = 1'b1;
    step();

    // 8N1, k=4, 0x55: 40-clock frame
    load_byte(8'h55);
    wait_done(100, n);
    check("lat_8n1", 32'(n), 32'd41);
    repeat (3) step();

    // 7E1, k=2, 0xC1: bit 7 ignored, 20 clocks
    set_cfg(0, 1, 0, 0, 2);
    load_byte(8'hC1);
    wait_done(100, n);
    check("lat_7e1", 32'(n), 32'd21);
    repeat (3) step();

    // 8O2, k=3, 0xA5: 36 clocks
    set_cfg(1, 1, 1, 1, 3);
    load_byte(8'hA5);
    wait_done(100, n);
    check("lat_8o2", 32'(n), 32'd37);
    repeat (3) step();

    // Fill past full with a slow first frame, then speed up the rest
    set_cfg(1, 0, 0, 0, 1000);
    d0 = n_done;
    for (int i = 0; i < 10; i++) begin
      ld = 1'b1;
      din = 8'(i);
      step();
    end
    ld = 1'b0;
    check("peak_count", 32'(fifo_count), 32'd8);
    check("full_txrdy", 32'(txrdy), 32'd0);
    check("ovf_set", 32'(overflow), 32'd1);
    k_i = K_W'(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    n = 0;
    while ((in_frame || q.size() > 0) && n < 20000) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n >= 20000), 32'd0);
    check("fill_frames", 32'(n_done - d0), 32'd9);
    repeat (3) step();

    // Two contiguous frames, 8N1 k=5
    set_cfg(1, 0, 0, 0, 5);
    d0 = n_done;
    load_byte(8'h3C);
    load_byte(8'hF0);
    n = 0;
    while (n_done < d0 + 2 && n < 300) begin
      step();
      n++;
    end
    check("b2b_frames", 32'(n_done - d0), 32'd2);
    check("b2b_interval", 32'(done_last - done_prev), 32'd50);
    repeat (3) step();

    // Reset mid-DATA with three bytes queued
    set_cfg(1, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) load_byte(8'h80 + 8'(i));
    repeat (8) step();
    rst_i = 1'b0;
    step();
    check("rst_transfer", 32'(transfer), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_txrdy", 32'(txrdy), 32'd1);
    rst_i = 1'b1;
    d0 = n_done;
    repeat (150) step();
    check("rst_no_frame", 32'(n_done - d0), 32'd0);

    // Randomized traffic with changing formats, divisors (incl. 0) and clears
    for (int i = 0; i < 4000; i++) begin
      ld = ($urandom_range(0, 2) == 0);
      din = 8'($urandom);
      set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      clr = ($urandom_range(0, 15) == 0);
      rst_i = ($urandom_range(0, 999) != 0);
      step();
    end
    ld = 1'b0; clr = 1'b0; rst_i = 1'b1;
    n = 0;
    while ((in_frame || q.size() > 0) && n < 2000) begin
      step();
      n++;
    end
    check("final_drain", 32'(n >= 2000), 32'd0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
